// File: rtl/spi_tx_scheduler.sv
// Feeds 12-bit words from a valid/ready source into an SPI loopback one frame at a time,
// checks each received word against the sent one and keeps pass/fail/timeout statistics.

module spi_tx_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_vld,
  output logic         wr_rdy,
  input  logic [W-1:0] wr_dat,
  output logic         rd_vld,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push, pop;

  // Full blocks the writer even when a read happens in the same cycle.
  assign wr_rdy = (cnt_q != (AW+1)'(DEPTH));
  assign rd_vld = (cnt_q != '0);
  assign rd_dat = mem_q[rd_ptr_q];
  assign push   = wr_vld && wr_rdy;
  assign pop    = rd_rdy && rd_vld;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_dat;
  end
endmodule

module spi_tx_scheduler #(
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 1024,
  parameter int GAP_CYC     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  input  logic [11:0] s_data,
  output logic        s_ready,
  output logic        newd,
  output logic [11:0] din,
  input  logic        done,
  input  logic [11:0] dout,
  output logic        rd_valid,
  output logic [11:0] rd_data,
  output logic        rd_match,
  output logic        busy,
  output logic [15:0] ok_cnt,
  output logic [15:0] err_cnt,
  output logic        timeout
);
  localparam int TW = $clog2(TIMEOUT_CYC + GAP_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_GAP} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [11:0]   din_q, din_d;
  logic          newd_q, newd_d;
  logic          done_q;
  logic          rd_valid_q, rd_valid_d;
  logic [11:0]   rd_data_q, rd_data_d;
  logic          rd_match_q, rd_match_d;
  logic [15:0]   ok_cnt_q, ok_cnt_d;
  logic [15:0]   err_cnt_q, err_cnt_d;
  logic          timeout_q, timeout_d;

  logic          fifo_rdy, fifo_vld, fifo_pop;
  logic [11:0]   fifo_dat;
  logic          done_rise;

  spi_tx_fifo #(.W(12), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (s_valid),
    .wr_rdy (fifo_rdy),
    .wr_dat (s_data),
    .rd_vld (fifo_vld),
    .rd_rdy (fifo_pop),
    .rd_dat (fifo_dat)
  );

  assign done_rise = done && !done_q;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    din_d      = din_q;
    newd_d     = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    rd_match_d = rd_match_q;
    ok_cnt_d   = ok_cnt_q;
    err_cnt_d  = err_cnt_q;
    timeout_d  = timeout_q;
    fifo_pop   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fifo_vld) begin
          fifo_pop = 1'b1;
          din_d    = fifo_dat;
          newd_d   = 1'b1;
          state_d  = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done edge in the expiry cycle still counts as a real completion.
        if (done_rise) begin
          rd_valid_d = 1'b1;
          rd_data_d  = dout;
          rd_match_d = (dout == din_q);
          if (dout == din_q) begin
            if (ok_cnt_q != 16'hFFFF) ok_cnt_d = ok_cnt_q + 16'd1;
          end else begin
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
          end
          timer_d = '0;
          state_d = S_GAP;
        end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
          rd_valid_d = 1'b1;
          rd_match_d = 1'b0;
          timeout_d  = 1'b1;
          if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
          timer_d = '0;
          state_d = S_GAP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_GAP: begin
        if (timer_q == TW'(GAP_CYC - 1)) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      din_q      <= '0;
      newd_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_match_q <= 1'b0;
      ok_cnt_q   <= '0;
      err_cnt_q  <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      din_q      <= din_d;
      newd_q     <= newd_d;
      done_q     <= done;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_match_q <= rd_match_d;
      ok_cnt_q   <= ok_cnt_d;
      err_cnt_q  <= err_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign s_ready  = fifo_rdy && !rst;
  assign newd     = newd_q;
  assign din      = din_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_match = rd_match_q;
  assign ok_cnt   = ok_cnt_q;
  assign err_cnt  = err_cnt_q;
  assign timeout  = timeout_q;
  assign busy     = (state_q != S_IDLE) || fifo_vld;
endmodule

// File: tb/tb_spi_tx_scheduler.sv
// Randomized scoreboard bench: a behavioural SPI responder answers each frame, a monitor
// compares every newd and rd_valid against queued expectations.

module tb_spi_tx_scheduler;
  localparam int DEPTH = 8;
  localparam int T     = 1024;
  localparam int G     = 4;

  typedef enum int {M_LOOP, M_CORRUPT, M_DISC, M_HOLD} kind_t;
  typedef struct {
    kind_t       kind;
    int          delay;
    int          hold;
    logic [11:0] cval;
  } mode_t;
  typedef struct {
    logic [11:0] data;
    logic        match;
    logic        tmo;
    int          cyc;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic [11:0] s_data;
  logic        s_ready;
  logic        newd;
  logic [11:0] din;
  logic        done;
  logic [11:0] dout;
  logic        rd_valid;
  logic [11:0] rd_data;
  logic        rd_match;
  logic        busy;
  logic [15:0] ok_cnt;
  logic [15:0] err_cnt;
  logic        timeout;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [11:0] sent_q[$];
  mode_t       mode_q[$];
  res_t        res_q[$];
  int          exp_ok, exp_err;
  logic        exp_tmo;
  logic [11:0] last_rd, prev_din;
  int          newd_cyc, last_rv_cyc;

  spi_tx_scheduler #(.DEPTH(DEPTH), .TIMEOUT_CYC(T), .GAP_CYC(G)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .newd(newd), .din(din), .done(done), .dout(dout), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_match(rd_match), .busy(busy), .ok_cnt(ok_cnt),
    .err_cnt(err_cnt), .timeout(timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: model state is cleared while reset is held.
  always @(negedge clk) begin
    if (rst) begin
      sent_q.delete(); mode_q.delete(); res_q.delete();
      exp_ok = 0; exp_err = 0; exp_tmo = 1'b0; last_rd = '0; prev_din = '0;
      newd_cyc = 0; last_rv_cyc = -1000;
    end else begin
      if (newd) begin
        if (sent_q.size() == 0) check("unexpected_newd", 1, 0);
        else check("din", din, sent_q.pop_front());
        check("gap_respected", (cyc - last_rv_cyc) >= G + 1, 1);
        newd_cyc = cyc;
      end else begin
        check("din_stable", din, prev_din);
      end
      prev_din = din;
      if (rd_valid) begin
        if (res_q.size() == 0) check("unexpected_rd_valid", 1, 0);
        else begin
          res_t e;
          e = res_q.pop_front();
          if (e.tmo) begin
            tests++;
            if ((cyc - newd_cyc) < T || (cyc - newd_cyc) > T + 1) begin
              fails++;
              $display("FAIL timeout_latency: got %0d expected %0d..%0d", cyc - newd_cyc, T, T + 1);
            end
            exp_tmo = 1'b1;
            if (exp_err < 16'hFFFF) exp_err++;
            check("rd_data_tmo", rd_data, last_rd);
            check("rd_match_tmo", rd_match, 0);
          end else begin
            check("rd_latency", cyc, e.cyc);
            if (e.match) begin if (exp_ok < 16'hFFFF) exp_ok++; end
            else begin if (exp_err < 16'hFFFF) exp_err++; end
            check("rd_data", rd_data, e.data);
            check("rd_match", rd_match, e.match);
            last_rd = e.data;
          end
          check("ok_cnt", ok_cnt, exp_ok);
          check("err_cnt", err_cnt, exp_err);
          check("timeout_flag", timeout, exp_tmo);
        end
        last_rv_cyc = cyc;
      end
    end
  end

  // Behavioural SPI loopback: answers each frame according to the mode queued with its word.
  initial begin
    mode_t m;
    res_t  e;
    logic [11:0] w;
    done = 1'b0;
    dout = '0;
    forever begin
      @(negedge clk);
      if (!rst && newd && mode_q.size() != 0) begin
        m = mode_q.pop_front();
        w = din;
        if (done) begin
          repeat (6) @(negedge clk);
          done = 1'b0;
          repeat (2) @(negedge clk);
        end
        if (m.kind == M_DISC) begin
          e = '{data: '0, match: 1'b0, tmo: 1'b1, cyc: 0};
          res_q.push_back(e);
        end else begin
          repeat (m.delay) @(negedge clk);
          dout = (m.kind == M_CORRUPT) ? m.cval : w;
          done = 1'b1;
          e = '{data: dout, match: (dout == w), tmo: 1'b0, cyc: cyc + 1};
          res_q.push_back(e);
          if (m.kind != M_HOLD) begin
            repeat (m.hold) @(negedge clk);
            done = 1'b0;
          end
        end
      end
    end
  end

  function automatic mode_t mk(input kind_t k, input int d, input int h, input logic [11:0] c);
    mode_t m;
    m.kind = k; m.delay = d; m.hold = h; m.cval = c;
    return m;
  endfunction

  task automatic push_word(input logic [11:0] w, input mode_t m);
    int n = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = w;
    while (!s_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      check("push_accept_timeout", 0, 1);
      s_valid = 1'b0;
    end else begin
      @(posedge clk);
      sent_q.push_back(w);
      mode_q.push_back(m);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_newd();
    int n = 0;
    while (!newd && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("newd_seen", newd, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((sent_q.size() != 0 || res_q.size() != 0 || busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", n < 5000, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_newd"}, newd, 0);
    check({tag, "_din"}, din, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_rd_match"}, rd_match, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ok_cnt"}, ok_cnt, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_timeout"}, timeout, 0);
  endtask

  initial begin
    logic [11:0] w;
    rst = 1'b1; s_valid = 1'b0; s_data = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check("reset_s_ready", s_ready, 1);

    // Single loopback word
    push_word(12'hA5C, mk(M_LOOP, 3, 2, '0));
    idle();
    drain();

    // Backpressure: first frame stalls in WAIT while the FIFO fills
    push_word(12'h101, mk(M_LOOP, 40, 1, '0));
    idle();
    wait_newd();
    for (int i = 0; i < 9; i++) begin
      push_word(12'(12'h200 + i), mk(M_LOOP, $urandom_range(1, 5), 1, '0));
      if (i == 7) begin
        @(negedge clk);
        check("full_s_ready", s_ready, 0);
        check("full_busy", busy, 1);
      end
    end
    idle();
    drain();

    // Disconnected slave then a normal frame queued behind it
    push_word(12'h3C3, mk(M_DISC, 0, 0, '0));
    push_word(12'h456, mk(M_LOOP, 2, 1, '0));
    idle();
    drain();

    // Corrupted return word
    push_word(12'hFFF, mk(M_CORRUPT, 4, 2, 12'h000));
    idle();
    drain();

    // Reset in the middle of a WAIT with three words queued
    push_word(12'h777, mk(M_DISC, 0, 0, '0));
    idle();
    wait_newd();
    for (int i = 0; i < 3; i++) push_word(12'(12'h610 + i), mk(M_LOOP, 2, 1, '0));
    idle();
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    check("midreset_s_ready", s_ready, 0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("post_reset_busy", busy, 0);
    check("post_reset_ok", ok_cnt, 0);
    push_word(12'h2B4, mk(M_LOOP, 3, 1, '0));
    idle();
    drain();

    // done held high across GAP into the next frame's WAIT
    push_word(12'h0F0, mk(M_HOLD, 3, 0, '0));
    push_word(12'h90E, mk(M_LOOP, 2, 1, '0));
    idle();
    drain();

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      w = 12'($urandom);
      if ($urandom_range(0, 3) == 0)
        push_word(w, mk(M_CORRUPT, $urandom_range(1, 10), $urandom_range(1, 3),
                        w ^ 12'($urandom_range(1, 4095))));
      else
        push_word(w, mk(M_LOOP, $urandom_range(1, 10), $urandom_range(1, 3), '0));
      if ($urandom_range(0, 1) == 1) begin
        idle();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    idle();
    drain();

    check("final_ok_cnt", ok_cnt, exp_ok);
    check("final_err_cnt", err_cnt, exp_err);
    check("final_timeout", timeout, exp_tmo);
    check("final_busy", busy, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
